// File: rtl/div3_pkg.sv
// Shared types and constants for the bit-serial divide-by-3 checker.
package div3_pkg;

    // Checker control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // Remainder encodings; 2'd3 is never produced
    localparam logic [1:0] REM0 = 2'd0;
    localparam logic [1:0] REM1 = 2'd1;
    localparam logic [1:0] REM2 = 2'd2;

    // 2^k mod 3 alternates 1, 2, 1, 2, ... with bit position
    localparam logic [1:0] W_EVEN = 2'd1;
    localparam logic [1:0] W_ODD  = 2'd2;

endpackage

// File: rtl/div3_rem_step.sv
// One step of the running mod-3 remainder: adds the weight of one input bit
// (1 at even positions, 2 at odd positions) modulo 3 without a wide add.
module div3_rem_step
    import div3_pkg::*;
(
    input  logic [1:0] rem,
    input  logic       data_bit,
    input  logic       odd_pos,
    output logic [1:0] rem_next
);

    logic [1:0] weight;

    // Modulo add over 0..2: +1 wraps 2->0, +2 is the same as -1 and wraps 0->2
    always_comb begin
        weight   = data_bit ? (odd_pos ? W_ODD : W_EVEN) : REM0;
        rem_next = rem;
        unique case (weight)
            W_EVEN:  rem_next = (rem == REM2) ? REM0 : rem + 2'd1;
            W_ODD:   rem_next = (rem == REM0) ? REM2 : rem - 2'd1;
            default: rem_next = rem;
        endcase
    end

endmodule

// File: rtl/div3_serial_checker.sv
// Bit-serial divisibility-by-3 checker. Takes a word over a valid/ready
// handshake, scans it LSB-first one bit per cycle and returns the value
// mod 3 plus a divisible flag over an output valid/ready handshake.
// Optional: define DIV3_DIFF_OUT_EN to add out_diff, the absolute difference
// between the popcounts of the odd and even bit positions.
module div3_serial_checker
    import div3_pkg::*;
#(
    parameter int unsigned DATA_LEN = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_LEN-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [1:0]          out_rem,
`ifdef DIV3_DIFF_OUT_EN
    output logic [DATA_LEN-1:0] out_diff,
`endif
    output logic                out_div3
);

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(DATA_LEN - 1);

    state_e              state_q, state_d;
    logic [1:0]          rem_q, rem_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [DATA_LEN-1:0] shreg_q, shreg_d;
    logic [1:0]          rem_step_nxt;

`ifdef DIV3_DIFF_OUT_EN
    // Popcounts never exceed DATA_LEN/2, so DATA_LEN bits is always enough
    logic [DATA_LEN-1:0] cnt_odd_q, cnt_odd_d;
    logic [DATA_LEN-1:0] cnt_even_q, cnt_even_d;
`endif

    div3_rem_step u_rem_step (
        .rem      (rem_q),
        .data_bit (shreg_q[0]),
        .odd_pos  (idx_q[0]),
        .rem_next (rem_step_nxt)
    );

    // State and datapath registers; reset aborts any scan in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rem_q      <= REM0;
            idx_q      <= '0;
            shreg_q    <= '0;
`ifdef DIV3_DIFF_OUT_EN
            cnt_odd_q  <= '0;
            cnt_even_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
`ifdef DIV3_DIFF_OUT_EN
            cnt_odd_q  <= cnt_odd_d;
            cnt_even_q <= cnt_even_d;
`endif
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
`ifdef DIV3_DIFF_OUT_EN
        cnt_odd_d  = cnt_odd_q;
        cnt_even_d = cnt_even_q;
`endif
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Held low while reset is asserted so no word is taken then
                in_ready = ~rst;
                if (in_valid && !rst) begin
                    shreg_d    = in_data;
                    rem_d      = REM0;
                    idx_d      = '0;
`ifdef DIV3_DIFF_OUT_EN
                    cnt_odd_d  = '0;
                    cnt_even_d = '0;
`endif
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                rem_d   = rem_step_nxt;
                shreg_d = shreg_q >> 1;
                idx_d   = idx_q + CNT_W'(1);
`ifdef DIV3_DIFF_OUT_EN
                if (shreg_q[0]) begin
                    if (idx_q[0]) cnt_odd_d  = cnt_odd_q + DATA_LEN'(1);
                    else          cnt_even_d = cnt_even_q + DATA_LEN'(1);
                end
`endif
                if (idx_q == LastIdx) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Result outputs read as zero except while a result is presented
    always_comb begin
        out_rem  = out_valid ? rem_q : REM0;
        out_div3 = out_valid && (rem_q == REM0);
`ifdef DIV3_DIFF_OUT_EN
        out_diff = '0;
        if (out_valid) begin
            out_diff = (cnt_odd_q >= cnt_even_q) ? cnt_odd_q - cnt_even_q
                                                 : cnt_even_q - cnt_odd_q;
        end
`endif
    end

endmodule

// File: tb/tb_div3_serial_checker.sv
// Scoreboard bench for div3_serial_checker: the driver tags each word with
// its hand-computed result, a negedge monitor pushes it on acceptance and
// pops/compares on every output handshake. Honours DIV3_DIFF_OUT_EN.
module tb_div3_serial_checker;

    localparam int DATA_LEN = 8;
    localparam int CNT_W    = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_LEN-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [1:0]          out_rem;
    logic                out_div3;
`ifdef DIV3_DIFF_OUT_EN
    logic [DATA_LEN-1:0] out_diff;
`endif

    typedef struct packed {
        logic [1:0]          rem;
        logic                div3;
        logic [DATA_LEN-1:0] diff;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur_exp;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_acc = -1;

    div3_serial_checker #(
        .DATA_LEN (DATA_LEN),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rem   (out_rem),
`ifdef DIV3_DIFF_OUT_EN
        .out_diff  (out_diff),
`endif
        .out_div3  (out_div3)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: acceptance, latency, stability under backpressure, result order
    initial begin : monitor
        logic       pv;
        logic       prdy;
        logic [1:0] prem;
        logic       pdiv;
        exp_t       e;
        pv = 1'b0; prdy = 1'b0; prem = '0; pdiv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb_q.delete();
                last_acc = -1;
                pv = 1'b0;
                continue;
            end
            if (in_valid && in_ready) begin
                if (last_acc >= 0)
                    check("accept_spacing", int'(cyc - last_acc >= DATA_LEN + 2), 1);
                sb_q.push_back(cur_exp);
                last_acc = cyc;
            end
            if (out_valid && !pv && last_acc >= 0)
                check("latency", cyc - last_acc, DATA_LEN + 1);
            if (pv && !prdy) begin
                check("hold_valid", out_valid, 1);
                check("hold_rem", out_rem, prem);
                check("hold_div3", out_div3, pdiv);
            end
            if (out_valid) check("in_ready_in_done", in_ready, 0);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 0, 1);
                end else begin
                    e = sb_q.pop_front();
                    check("out_rem", out_rem, e.rem);
                    check("out_div3", out_div3, e.div3);
`ifdef DIV3_DIFF_OUT_EN
                    check("out_diff", out_diff, e.diff);
`endif
                end
            end
            pv = out_valid; prdy = out_ready; prem = out_rem; pdiv = out_div3;
        end
    end

    // Present a word until accepted; returns 1 ns after the accepting edge
    task automatic send(input logic [7:0] data, input logic [1:0] rem, input logic [7:0] diff);
        logic got;
        got = 1'b0;
        in_data  = data;
        in_valid = 1'b1;
        cur_exp.rem  = rem;
        cur_exp.div3 = (rem == 2'd0);
        cur_exp.diff = diff;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            if (got) break;
        end
        if (!got) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    task automatic wait_out_valid();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            ok = out_valid;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) check("out_valid_timeout", 0, 1);
    endtask

    // Directed words with hand-computed mod-3 value and |odd-even| popcount difference
    typedef struct packed {
        logic [7:0] data;
        logic [1:0] rem;
        logic [7:0] diff;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{data: 8'h07, rem: 2'd1, diff: 8'd1};
        vecs[1] = '{data: 8'h05, rem: 2'd2, diff: 8'd2};
        vecs[2] = '{data: 8'hFF, rem: 2'd0, diff: 8'd0};
        vecs[3] = '{data: 8'hAA, rem: 2'd2, diff: 8'd4};
        vecs[4] = '{data: 8'h55, rem: 2'd1, diff: 8'd4};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cur_exp = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_rem", out_rem, 0);
        check("rst_out_div3", out_div3, 0);
`ifdef DIV3_DIFF_OUT_EN
        check("rst_out_diff", out_diff, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // All zeros is divisible
        send(8'h00, 2'd0, 8'd0);
        in_valid = 1'b0;
        wait_idle();

        for (int i = 0; i < 5; i++) begin
            send(vecs[i].data, vecs[i].rem, vecs[i].diff);
            in_valid = 1'b0;
            wait_idle();
        end

        // Backpressure: 14 mod 3 = 2, odd bits {1,3}, even bit {2}
        out_ready = 1'b0;
        send(8'h0E, 2'd2, 8'd1);
        in_valid = 1'b0;
        wait_out_valid();
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);

        // Second word held on in_valid during the scan of the first
        send(8'h03, 2'd0, 8'd0);
        send(8'h04, 2'd1, 8'd1);
        in_valid = 1'b0;
        wait_idle();

        // Reset in the middle of a scan discards the partial result
        send(8'h07, 2'd1, 8'd1);
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        check("mid_rst_in_ready_held", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'h06, 2'd0, 8'd0);
        in_valid = 1'b0;
        wait_out_valid();
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
